// File: rtl/hmc_ctrl_pkg.sv
// ============================================================================
//  Module      : hmc_ctrl_pkg
//  Description : Shared HMC controller types and constants.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package hmc_ctrl_pkg;

    localparam int unsigned MAX_PKT_LNG = 9;

    typedef enum logic [1:0] {
        ST_UNINIT = 2'd0,
        ST_RUN    = 2'd1,
        ST_ERR    = 2'd2
    } arb_state_t;

    function automatic logic lng_is_legal(input logic [3:0] lng);
        return (lng != 4'd0) && (lng <= 4'(MAX_PKT_LNG));
    endfunction

endpackage

`default_nettype wire

// File: rtl/hmc_rr_arb2.sv
// ============================================================================
//  Module      : hmc_rr_arb2
//  Description : Two-way round-robin pointer and per-cycle candidate select.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module hmc_rr_arb2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] i_req_valid,
    input  logic       i_xfer,
    input  logic       i_xfer_idx,
    output logic       o_cand_valid,
    output logic       o_cand_idx
);

    logic r_ptr;

    // After a transfer the other requester gets first look next cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr <= 1'b0;
        end else if (i_xfer) begin
            r_ptr <= ~i_xfer_idx;
        end
    end

    always_comb begin
        o_cand_valid = |i_req_valid;
        o_cand_idx   = i_req_valid[r_ptr] ? r_ptr : ~r_ptr;
    end

endmodule

`default_nettype wire

// File: rtl/hmc_tx_token_arbiter.sv
// ============================================================================
//  Module      : hmc_tx_token_arbiter
//  Description : Token-gated round-robin arbiter for the HMC TX path.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module hmc_tx_token_arbiter
    import hmc_ctrl_pkg::*;
#(
    parameter int LOG_MAX_HMC_TOKENS = 10,
    parameter int TRET_W             = 6
) (
    input  logic                          clk_hmc,
    input  logic                          res_n,
    input  logic                          cfg_load,
    input  logic [LOG_MAX_HMC_TOKENS-1:0] cfg_init_tokens,
    input  logic [1:0]                    req_valid,
    input  logic [1:0][3:0]               req_lng,
    output logic [1:0]                    req_ready,
    input  logic                          tret_valid,
    input  logic [TRET_W-1:0]             tret_count,
    output logic [LOG_MAX_HMC_TOKENS-1:0] tokens_avail,
    output logic [1:0]                    arb_state,
    output logic                          err_sticky
);

    localparam int c_sum_w = LOG_MAX_HMC_TOKENS + 2;
    localparam logic [c_sum_w-1:0] c_tok_max = {2'b00, {LOG_MAX_HMC_TOKENS{1'b1}}};

    arb_state_t                    r_state;
    logic [LOG_MAX_HMC_TOKENS-1:0] r_count;
    logic                          r_err;

    logic                          w_cand_valid;
    logic                          w_cand_idx;
    logic [3:0]                    w_cand_lng;
    logic                          w_lng_legal;
    logic                          w_fits;
    logic                          w_grant;
    logic                          w_xfer;
    logic                          w_illegal;
    logic [c_sum_w-1:0]            w_dec;
    logic [c_sum_w-1:0]            w_inc;
    logic [c_sum_w-1:0]            w_sum;
    logic                          w_ovf;
    logic [LOG_MAX_HMC_TOKENS-1:0] w_count_sat;

    hmc_rr_arb2 u_rr_arb (
        .clk          (clk_hmc),
        .rst_n        (res_n),
        .i_req_valid  (req_valid),
        .i_xfer       (w_xfer),
        .i_xfer_idx   (w_cand_idx),
        .o_cand_valid (w_cand_valid),
        .o_cand_idx   (w_cand_idx)
    );

    // Only the candidate may be granted; a short packet behind a blocked
    // candidate waits, so long packets cannot be starved.
    always_comb begin
        w_cand_lng  = req_lng[w_cand_idx];
        w_lng_legal = lng_is_legal(w_cand_lng);
        w_fits      = c_sum_w'(r_count) >= c_sum_w'(w_cand_lng);
        w_grant     = (r_state == ST_RUN) && !cfg_load && w_cand_valid
                      && w_lng_legal && w_fits;
        req_ready   = w_grant ? (w_cand_idx ? 2'b10 : 2'b01) : 2'b00;
        w_xfer      = |(req_valid & req_ready);
        w_illegal   = (r_state == ST_RUN) && w_cand_valid && !w_lng_legal;
    end

    always_comb begin
        w_dec       = w_xfer ? c_sum_w'(w_cand_lng) : '0;
        w_inc       = tret_valid ? c_sum_w'(tret_count) : '0;
        w_sum       = c_sum_w'(r_count) - w_dec + w_inc;
        w_ovf       = w_sum > c_tok_max;
        w_count_sat = w_ovf ? {LOG_MAX_HMC_TOKENS{1'b1}} : w_sum[LOG_MAX_HMC_TOKENS-1:0];
    end

    always_ff @(posedge clk_hmc or negedge res_n) begin
        if (!res_n) begin
            r_state <= ST_UNINIT;
            r_count <= '0;
            r_err   <= 1'b0;
        end else if (cfg_load) begin
            r_state <= ST_RUN;
            r_count <= cfg_init_tokens;
            r_err   <= 1'b0;
        end else begin
            // Returns keep saturating outside RUN; only RUN raises errors.
            r_count <= w_count_sat;
            case (r_state)
                ST_RUN: begin
                    if (w_ovf || w_illegal) begin
                        r_state <= ST_ERR;
                        r_err   <= 1'b1;
                    end
                end
                ST_UNINIT, ST_ERR: begin
                end
                default: begin
                    r_state <= ST_ERR;
                    r_err   <= 1'b1;
                end
            endcase
        end
    end

    assign tokens_avail = r_count;
    assign arb_state    = r_state;
    assign err_sticky   = r_err;

endmodule

`default_nettype wire

// File: tb/tb_hmc_tx_token_arbiter.sv
// ============================================================================
//  Module      : tb_hmc_tx_token_arbiter
//  Description : Directed and randomized bench for hmc_tx_token_arbiter.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_hmc_tx_token_arbiter;

    localparam int W       = 10;
    localparam int TRET_W  = 6;
    localparam int TOK_MAX = (1 << W) - 1;

    logic              clk_hmc;
    logic              res_n;
    logic              cfg_load;
    logic [W-1:0]      cfg_init_tokens;
    logic [1:0]        req_valid;
    logic [1:0][3:0]   req_lng;
    logic [1:0]        req_ready;
    logic              tret_valid;
    logic [TRET_W-1:0] tret_count;
    logic [W-1:0]      tokens_avail;
    logic [1:0]        arb_state;
    logic              err_sticky;

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model: 0=UNINIT 1=RUN 2=ERR, plain integer token count.
    int         m_state;
    int         m_count;
    int         m_ptr;
    logic       m_err;
    logic [1:0] m_ready;

    hmc_tx_token_arbiter #(
        .LOG_MAX_HMC_TOKENS (W),
        .TRET_W             (TRET_W)
    ) dut (
        .clk_hmc         (clk_hmc),
        .res_n           (res_n),
        .cfg_load        (cfg_load),
        .cfg_init_tokens (cfg_init_tokens),
        .req_valid       (req_valid),
        .req_lng         (req_lng),
        .req_ready       (req_ready),
        .tret_valid      (tret_valid),
        .tret_count      (tret_count),
        .tokens_avail    (tokens_avail),
        .arb_state       (arb_state),
        .err_sticky      (err_sticky)
    );

    initial clk_hmc = 1'b0;
    always #5 clk_hmc = ~clk_hmc;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_state = 0;
        m_count = 0;
        m_ptr   = 0;
        m_err   = 1'b0;
        m_ready = 2'b00;
    endtask

    function automatic int cand_of();
        return req_valid[m_ptr] ? m_ptr : 1 - m_ptr;
    endfunction

    function automatic logic [1:0] model_ready();
        int c;
        int l;
        if (cfg_load || m_state != 1 || req_valid == 2'b00) return 2'b00;
        c = cand_of();
        l = int'(req_lng[c]);
        if (l < 1 || l > 9) return 2'b00;
        if (m_count >= l) return (c == 1) ? 2'b10 : 2'b01;
        return 2'b00;
    endfunction

    task automatic model_clock();
        int  c;
        int  l;
        int  sum;
        bit  illegal;
        if (cfg_load) begin
            m_state = 1;
            m_count = int'(cfg_init_tokens);
            m_err   = 1'b0;
            return;
        end
        c       = cand_of();
        l       = int'(req_lng[c]);
        illegal = (m_state == 1) && (req_valid != 2'b00) && (l < 1 || l > 9);
        sum     = m_count + (tret_valid ? int'(tret_count) : 0);
        if (m_ready != 2'b00) begin
            sum   = sum - l;
            m_ptr = 1 - c;
        end
        if (sum > TOK_MAX) begin
            sum = TOK_MAX;
            if (m_state == 1) begin
                m_state = 2;
                m_err   = 1'b1;
            end
        end
        if (illegal) begin
            m_state = 2;
            m_err   = 1'b1;
        end
        m_count = sum;
    endtask

    // Entered just after a falling edge with inputs already applied.
    task automatic step(input string tag);
        #1;
        m_ready = model_ready();
        chk({tag, ".ready"}, 32'(req_ready), 32'(m_ready));
        @(posedge clk_hmc);
        model_clock();
        @(negedge clk_hmc);
        chk({tag, ".tokens"}, 32'(tokens_avail), 32'(m_count));
        chk({tag, ".state"},  32'(arb_state),    32'(m_state));
        chk({tag, ".err"},    32'(err_sticky),   32'(m_err));
    endtask

    initial begin
        logic [1:0] exp_seq [6];
        logic [1:0] pend;
        logic       was_load;

        exp_seq = '{2'b01, 2'b10, 2'b01, 2'b10, 2'b01, 2'b00};
        res_n = 1'b0; cfg_load = 1'b0; cfg_init_tokens = '0;
        req_valid = 2'b00; req_lng = '0; tret_valid = 1'b0; tret_count = '0;
        model_reset();

        // Reset state
        @(negedge clk_hmc);
        @(negedge clk_hmc);
        #1;
        chk("rst.tokens", 32'(tokens_avail), 32'd0);
        chk("rst.state",  32'(arb_state),    32'd0);
        chk("rst.err",    32'(err_sticky),   32'd0);
        chk("rst.ready",  32'(req_ready),    32'd0);
        @(negedge clk_hmc);
        res_n = 1'b1;

        // Alternating grants drain 20 tokens in five packets of four
        cfg_load = 1'b1; cfg_init_tokens = 10'd20;
        step("load20");
        cfg_load = 1'b0;
        req_valid = 2'b11; req_lng[0] = 4'd4; req_lng[1] = 4'd4;
        for (int i = 0; i < 6; i++) begin
            #1 chk("alt.seq", 32'(req_ready), 32'(exp_seq[i]));
            step("alt");
        end
        chk("alt.drained", 32'(tokens_avail), 32'd0);
        req_valid = 2'b00;

        // Head-of-line blocking with pointer on requester 1
        tret_valid = 1'b1; tret_count = 6'd3;
        step("hol.fill");
        req_valid = 2'b11; req_lng[1] = 4'd5; req_lng[0] = 4'd1;
        tret_count = 6'd2;
        #1 chk("hol.block", 32'(req_ready), 32'd0);
        step("hol.ret");
        tret_valid = 1'b0;
        #1 chk("hol.grant", 32'(req_ready), 32'b10);
        step("hol.xfer");
        chk("hol.count", 32'(tokens_avail), 32'd0);
        req_valid = 2'b00;

        // Simultaneous grant and return reach the ceiling, one more overflows
        cfg_load = 1'b1; cfg_init_tokens = 10'd1020;
        step("ovf.load");
        cfg_load = 1'b0;
        req_valid = 2'b01; req_lng[0] = 4'd2;
        tret_valid = 1'b1; tret_count = 6'd5;
        step("ovf.mix");
        chk("ovf.max",   32'(tokens_avail), 32'd1023);
        chk("ovf.noerr", 32'(err_sticky),   32'd0);
        req_valid = 2'b00; tret_count = 6'd1;
        step("ovf.over");
        chk("ovf.state", 32'(arb_state),  32'd2);
        chk("ovf.err",   32'(err_sticky), 32'd1);
        tret_valid = 1'b0; req_valid = 2'b01;
        #1 chk("ovf.noready", 32'(req_ready), 32'd0);
        step("ovf.hold");
        tret_valid = 1'b1; tret_count = 6'd7;
        step("ovf.satret");
        chk("ovf.sat", 32'(tokens_avail), 32'd1023);
        tret_valid = 1'b0; req_valid = 2'b00;

        // Illegal zero length, then recovery by cfg_load
        cfg_load = 1'b1; cfg_init_tokens = 10'd8;
        step("ill.load");
        cfg_load = 1'b0;
        req_valid = 2'b01; req_lng[0] = 4'd0;
        step("ill.zero");
        chk("ill.state", 32'(arb_state), 32'd2);
        req_valid = 2'b00;
        cfg_load = 1'b1; cfg_init_tokens = 10'd8;
        step("ill.reload");
        chk("ill.run",   32'(arb_state),    32'd1);
        chk("ill.clear", 32'(err_sticky),   32'd0);
        chk("ill.count", 32'(tokens_avail), 32'd8);
        cfg_load = 1'b0;

        // Asynchronous reset while a grant is showing
        req_valid = 2'b01; req_lng[0] = 4'd3;
        #1 chk("ares.pre", 32'(req_ready), 32'b01);
        #2 res_n = 1'b0;
        #1;
        chk("ares.ready",  32'(req_ready),    32'd0);
        chk("ares.tokens", 32'(tokens_avail), 32'd0);
        chk("ares.state",  32'(arb_state),    32'd0);
        model_reset();
        req_valid = 2'b00;
        @(negedge clk_hmc);
        res_n = 1'b1;
        @(negedge clk_hmc);

        // Randomized traffic with requesters honouring the hold-until-transfer rule
        pend = 2'b00;
        cfg_load = 1'b1; cfg_init_tokens = 10'd100;
        step("rnd.load");
        cfg_load = 1'b0;
        for (int n = 0; n < 400; n++) begin
            for (int i = 0; i < 2; i++) begin
                if (!pend[i] && ($urandom % 3 == 0)) begin
                    pend[i] = 1'b1;
                    if ($urandom % 40 == 0)
                        req_lng[i] = ($urandom % 2 == 0) ? 4'd0 : 4'($urandom_range(10, 15));
                    else
                        req_lng[i] = 4'($urandom_range(1, 9));
                end
            end
            req_valid  = pend;
            tret_valid = ($urandom % 3 == 0);
            tret_count = 6'($urandom_range(0, 12));
            cfg_load   = ($urandom % 64 == 0) || (m_state != 1 && ($urandom % 6 == 0));
            cfg_init_tokens = 10'($urandom_range(0, 60));
            was_load = cfg_load;
            step("rnd");
            pend = pend & ~m_ready;
            if (was_load) pend = 2'b00;
        end
        cfg_load = 1'b0; req_valid = 2'b00; tret_valid = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/hmc_tx_token_arbiter.md
HMC_TX_TOKEN_ARBITER -- requirements
Module: hmc_tx_token_arbiter

Interface
REQ-001 SHALL have parameter LOG_MAX_HMC_TOKENS, default 10, width of the HMC input-buffer token counter.
REQ-002 SHALL have parameter TRET_W, default 6, width of the per-cycle token-return count.
REQ-003 SHALL have port clk_hmc, input, 1: the single clock; all logic rising-edge.
REQ-004 SHALL have port res_n, input, 1: reset, asynchronous, active-low.
REQ-005 SHALL have port cfg_load, input, 1: one-cycle pulse that loads the token counter.
REQ-006 SHALL have port cfg_init_tokens, input, LOG_MAX_HMC_TOKENS: the token value loaded by cfg_load.
REQ-007 SHALL have port req_valid, input, 2: per-requester packet request; [0] = retry/replay path, [1] = user request path.
REQ-008 SHALL have port req_lng, input, 2x4: per-requester packet length in FLITs, 1..9.
REQ-009 SHALL have port req_ready, output, 2: per-requester grant, at most one bit set.
REQ-010 SHALL have port tret_valid, input, 1: token-return strobe.
REQ-011 SHALL have port tret_count, input, TRET_W: number of tokens returned when tret_valid=1.
REQ-012 SHALL have port tokens_avail, output, LOG_MAX_HMC_TOKENS: registered token count.
REQ-013 SHALL have port arb_state, output, 2: current FSM state encoding.
REQ-014 SHALL have port err_sticky, output, 1: set on overflow or illegal length; cleared only by cfg_load or reset.

Function
REQ-015 SHALL implement the FSM states UNINIT=0, RUN=1 and ERR=2.
REQ-016 SHALL move from any state to RUN on cfg_load, setting count=cfg_init_tokens and err_sticky=0; cfg_load overrides every same-cycle event, and that cycle performs no transfer.
REQ-017 SHALL hold req_ready=0 in UNINIT and ERR.
REQ-018 In RUN, SHALL select a candidate per cycle: the pointer requester if valid, else the other requester if valid.
REQ-019 SHALL drive req_ready combinationally, asserting it for the candidate only when count >= its req_lng.
REQ-020 SHALL grant no requester when the candidate has insufficient tokens, even if the other requester would fit; this is deliberate head-of-line blocking to prevent starvation of long packets.
REQ-021 SHALL define a transfer as req_valid[i] & req_ready[i]; a requester SHALL hold req_valid and req_lng stable until its transfer.
REQ-022 SHALL, on each transfer to requester i, set the round-robin pointer to the other requester; with no transfer the pointer is held; reset value of the pointer is 0.
REQ-023 SHALL compute next count = count - granted_lng + (tret_valid ? tret_count : 0) in LOG_MAX_HMC_TOKENS+2 bits, with a same-cycle grant and return both applied.
REQ-024 SHALL, when the result exceeds 2^LOG_MAX_HMC_TOKENS-1, enter ERR, set err_sticky and saturate count at the maximum.
REQ-025 SHALL treat a valid candidate with req_lng of 0 or >9 as illegal: ERR and err_sticky are set, and no transfer occurs.
REQ-026 SHALL continue to accept token returns in UNINIT and ERR, saturating at the maximum without further error.
REQ-027 SHALL register tokens_avail, arb_state and err_sticky, so they reflect an event one cycle after it; req_ready has zero latency from req_valid.

Reset
REQ-028 SHALL, while res_n=0, asynchronously drive state UNINIT, count=0, pointer=0 and err_sticky=0, giving tokens_avail=0, arb_state=0 and req_ready=0.
REQ-029 SHALL, on reset mid-transfer, discard the in-flight grant; requesters re-present after cfg_load.

Structure
REQ-030 SHALL take the state enum and constant MAX_PKT_LNG=9 from the shared package hmc_ctrl_pkg; LOG_MAX_HMC_TOKENS SHALL be passed from the top-level parameter set.
REQ-031 SHALL contain one sub-module, hmc_rr_arb2, holding the 2-way round-robin pointer and the candidate select; token accounting and the FSM SHALL remain in the top module.

Verification
REQ-032 SHALL cover: reset, then cfg_load with 20; req_valid=2'b11, lng 4/4 -> grants alternate 0,1,0,1,0 and tokens_avail reaches 0; no sixth grant.
REQ-033 SHALL cover: count=3, pointer=1, req[1] lng=5, req[0] lng=1 -> no grant; tret_count=2 -> req[1] granted next cycle, count=0.
REQ-034 SHALL cover: count=1020, grant lng 2 plus tret 5 in the same cycle -> count=1023, no error; then tret 1 -> ERR, err_sticky=1, req_ready=0.
REQ-035 SHALL cover: req_lng=0 on the candidate -> ERR, no transfer; then cfg_load 8 -> RUN, err_sticky=0, count=8.
REQ-036 SHALL cover: res_n asserted while req_ready=1 -> req_ready=0 immediately, tokens_avail=0, arb_state=UNINIT.
